// File: rtl/math_pow2_arb.sv
// math_pow2_arb
//
// Purpose
//   Arbitrates NREQ requesters onto one shared, externally instantiated pow2
//   unit with a fixed 2-cycle latency. Each granted 12-bit 6.6 operand goes
//   out on pow_din. A 2-stage tag pipeline carries the requester index
//   alongside that operand. When the result appears on pow_dout, the result
//   and its index are pushed into a result FIFO. The FIFO then drains through
//   a valid/ready handshake.
//
//   A grant is only given when the in-flight operations plus the buffered
//   results leave room in the FIFO. As a result, a push can never find the
//   FIFO full, and results come back in issue order.
//
// Configuration
//   MATH_POW2_ARB_PRIO_EN : when defined, requester 0 has strict priority,
//                           and requesters 1-3 share a round-robin among
//                           themselves. When undefined, a plain 4-way
//                           round-robin is used.
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : asynchronous reset, active low
//   req_valid  : per-requester request valid
//   req_data   : packed 12-bit operands; requester i uses [12i+11:12i]
//   req_ready  : per-requester grant; at most one bit set
//   pow_din    : operand to the pow2 unit; zero when nothing is issued
//   pow_dout   : pow2 unit result, valid 2 cycles after pow_din
//   rsp_valid  : result FIFO not empty
//   rsp_ready  : consumer accepts the head result
//   rsp_data   : head result
//   rsp_id     : requester index of the head result
//   busy       : operations in flight or results buffered
module math_pow2_arb #(
  parameter int NREQ      = 4,
  parameter int RSP_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ*12-1:0]  req_data,
  output logic [NREQ-1:0]     req_ready,
  output logic [11:0]         pow_din,
  input  logic [33:0]         pow_dout,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [33:0]         rsp_data,
  output logic [1:0]          rsp_id,
  output logic                busy
);

  localparam int OPW  = 12;
  localparam int RESW = 34;
  localparam int IDW  = 2;
  localparam int AW   = $clog2(RSP_DEPTH);
  localparam int CW   = AW + 1;
  localparam int EW   = RESW + IDW;

  // Arbitration state: the index where the next search starts.
  logic [IDW-1:0]  grantPtr_q, grantPtr_d;

  // Tag pipeline that runs alongside the external pow2 unit.
  logic            tagValid1_q, tagValid2_q;
  logic [IDW-1:0]  tagId1_q, tagId2_q;

  // Result FIFO.
  logic [EW-1:0]   fifoMem_q [RSP_DEPTH];
  logic [AW-1:0]   wrPtr_q, wrPtr_d;
  logic [AW-1:0]   rdPtr_q, rdPtr_d;
  logic [CW-1:0]   fifoCount_q, fifoCount_d;

  // Combinational helpers.
  logic [OPW-1:0]  operand [NREQ];
  logic [CW-1:0]   inflight;
  logic [CW:0]     creditUse;
  logic            hasCredit;
  logic            candAny;
  logic [IDW-1:0]  candIdx;
  logic [IDW-1:0]  searchIdx;
  logic            issue;
  logic [NREQ-1:0] grantOh;
  logic            push;
  logic            pop;
  logic [EW-1:0]   headEntry;

  // Split the packed operand bus into one operand per requester.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      operand[i] = req_data[i*OPW +: OPW];
    end
  end

  // Credit: every issued operation must already own a FIFO slot.
  // Counting in-flight tags together with buffered results guarantees that
  // a push never meets a full FIFO, so no full check is needed on the write.
  always_comb begin
    inflight  = CW'(tagValid1_q) + CW'(tagValid2_q);
    creditUse = {1'b0, inflight} + {1'b0, fifoCount_q};
    hasCredit = creditUse < (CW+1)'(RSP_DEPTH);
  end

  // Candidate selection. The search starts at grantPtr_q and wraps around.
  // In priority mode, requester 0 wins outright, and index 0 is skipped
  // while rotating through requesters 1-3.
  always_comb begin
    candAny   = 1'b0;
    candIdx   = '0;
    searchIdx = '0;
`ifdef MATH_POW2_ARB_PRIO_EN
    if (req_valid[0]) begin
      candAny = 1'b1;
      candIdx = '0;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        searchIdx = grantPtr_q + IDW'(k);
        if (!candAny && (searchIdx != '0) && req_valid[searchIdx]) begin
          candAny = 1'b1;
          candIdx = searchIdx;
        end
      end
    end
`else
    for (int k = 0; k < NREQ; k++) begin
      searchIdx = grantPtr_q + IDW'(k);
      if (!candAny && req_valid[searchIdx]) begin
        candAny = 1'b1;
        candIdx = searchIdx;
      end
    end
`endif
  end

  // The grant is qualified by credit and by rst_n. Gating with rst_n keeps
  // req_ready and pow_din at zero while reset is held, even when requesters
  // are valid. rsp_ready is deliberately not part of this path.
  always_comb begin
    issue   = candAny && hasCredit && rst_n;
    grantOh = '0;
    if (issue) begin
      grantOh[candIdx] = 1'b1;
    end
    req_ready = grantOh;
    pow_din   = issue ? operand[candIdx] : '0;
  end

  // Pointer next state: after an issue, the search resumes just past the
  // winner. In priority mode, a grant to requester 0 leaves the 1-3
  // rotation untouched.
  always_comb begin
    grantPtr_d = grantPtr_q;
`ifdef MATH_POW2_ARB_PRIO_EN
    if (issue && (candIdx != '0)) begin
      grantPtr_d = candIdx + IDW'(1);
    end
`else
    if (issue) begin
      grantPtr_d = candIdx + IDW'(1);
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grantPtr_q <= '0;
    end else begin
      grantPtr_q <= grantPtr_d;
    end
  end

  // Tag pipeline. Clearing it on reset guarantees that late pow_dout values
  // from operations issued before reset are never written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tagValid1_q <= 1'b0;
      tagValid2_q <= 1'b0;
      tagId1_q    <= '0;
      tagId2_q    <= '0;
    end else begin
      tagValid1_q <= issue;
      tagId1_q    <= candIdx;
      tagValid2_q <= tagValid1_q;
      tagId2_q    <= tagId1_q;
    end
  end

  // FIFO control. The stage-2 tag lines up with pow_dout. A push and a pop
  // in the same cycle leave the count unchanged.
  always_comb begin
    push        = tagValid2_q;
    pop         = rsp_valid && rsp_ready;
    wrPtr_d     = wrPtr_q;
    rdPtr_d     = rdPtr_q;
    fifoCount_d = fifoCount_q;
    if (push) begin
      wrPtr_d = wrPtr_q + AW'(1);
    end
    if (pop) begin
      rdPtr_d = rdPtr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   fifoCount_d = fifoCount_q + CW'(1);
      2'b01:   fifoCount_d = fifoCount_q - CW'(1);
      default: fifoCount_d = fifoCount_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      fifoCount_q <= '0;
    end else begin
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      fifoCount_q <= fifoCount_d;
    end
  end

  // Storage needs no reset, because the count alone decides validity.
  always_ff @(posedge clk) begin
    if (push) begin
      fifoMem_q[wrPtr_q] <= {pow_dout, tagId2_q};
    end
  end

  // The head stays put until it is popped, so the outputs hold steady
  // while the consumer stalls.
  always_comb begin
    headEntry = fifoMem_q[rdPtr_q];
    rsp_valid = fifoCount_q != '0;
    rsp_data  = headEntry[EW-1:IDW];
    rsp_id    = headEntry[IDW-1:0];
    busy      = (inflight != '0) || (fifoCount_q != '0);
  end

endmodule

// File: tb/tb_math_pow2_arb.sv
// Testbench for math_pow2_arb.
// Includes a behavioural 2-cycle pow2 stand-in whose output is
// 1 << integer_part(operand). Stimulus pushes expected {data, id} entries
// into a scoreboard queue, and a monitor compares the DUT head against the
// queue front whenever rsp_valid is high.
module tb_math_pow2_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [47:0] req_data;
  logic [3:0]  req_ready;
  logic [11:0] pow_din;
  logic [33:0] pow_dout;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [33:0] rsp_data;
  logic [1:0]  rsp_id;
  logic        busy;

  int errors = 0;
  int checks = 0;
  logic [35:0] sbQ[$];

  logic [33:0] powStage1 = '0;
  logic [33:0] powStage2 = '0;

  math_pow2_arb #(.NREQ(4), .RSP_DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .pow_din   (pow_din),
    .pow_dout  (pow_dout),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Stand-in for the shared 2-cycle pow2 unit.
  always @(posedge clk) begin
    powStage1 <= 34'd1 << pow_din[11:6];
    powStage2 <= powStage1;
  end
  assign pow_dout = powStage2;

  function automatic logic [47:0] packOps(input logic [11:0] o0, input logic [11:0] o1,
                                          input logic [11:0] o2, input logic [11:0] o3);
    return {o3, o2, o1, o0};
  endfunction

  task automatic checkOutput(input string name, input logic [35:0] actual, input logic [35:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  // Drives one cycle of requests, checks the grant and the pow_din operand,
  // and records the expected response.
  task automatic applyStimulus(input logic [3:0] valid, input logic [3:0] expReady,
                               input logic [33:0] expData, input bit expectRsp, input string name);
    logic [11:0] expOp;
    logic [1:0]  expId;
    expOp = '0;
    expId = '0;
    req_valid = valid;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      if (expReady[i]) begin
        expOp = req_data[i*12 +: 12];
        expId = 2'(i);
      end
    end
    checkOutput({name, ".ready"}, 36'(req_ready), 36'(expReady));
    checkOutput({name, ".din"}, 36'(pow_din), 36'(expOp));
    if ((expReady != 4'b0000) && expectRsp) begin
      sbQ.push_back({expData, expId});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic waitIdle(input int maxCycles, input string name);
    int n;
    n = 0;
    @(negedge clk);
    while ((busy !== 1'b0) && (n < maxCycles)) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, 36'(busy), 36'd0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares the head against the scoreboard and pops on handshake.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && rsp_valid === 1'b1) begin
      if (sbQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL mon.unexpected actual=%h_%0d expected=none", rsp_data, rsp_id);
      end else begin
        checkOutput("mon.rsp", {rsp_data, rsp_id}, sbQ[0]);
        if (rsp_ready === 1'b1) begin
          void'(sbQ.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = 4'hF;
    req_data  = packOps(12'h000, 12'h040, 12'h080, 12'h0C0);
    rsp_ready = 1'b1;

    // Reset values, with requests already pending.
    repeat (2) @(negedge clk);
    checkOutput("reset.ready", 36'(req_ready), 36'd0);
    checkOutput("reset.rspValid", 36'(rsp_valid), 36'd0);
    checkOutput("reset.busy", 36'(busy), 36'd0);
    checkOutput("reset.din", 36'(pow_din), 36'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Grants start in the first cycle after reset; all four valid.
`ifdef MATH_POW2_ARB_PRIO_EN
    for (int i = 0; i < 5; i++) applyStimulus(4'hF, 4'b0001, 34'd1, 1'b1, "rr");
`else
    applyStimulus(4'hF, 4'b0001, 34'd1, 1'b1, "rr0");
    applyStimulus(4'hF, 4'b0010, 34'd2, 1'b1, "rr1");
    applyStimulus(4'hF, 4'b0100, 34'd4, 1'b1, "rr2");
    applyStimulus(4'hF, 4'b1000, 34'd8, 1'b1, "rr3");
    applyStimulus(4'hF, 4'b0001, 34'd1, 1'b1, "rr4");
`endif
    req_valid = 4'h0;
    waitIdle(20, "rr.idle");

    // Single request from requester 2 with operand 0; result appears at T+3.
    req_data = packOps(12'h040, 12'h080, 12'h000, 12'h0C0);
    applyStimulus(4'b0100, 4'b0100, 34'd1, 1'b1, "single");
    req_valid = 4'h0;
    @(negedge clk);
    checkOutput("single.lat1", 36'(rsp_valid), 36'd0);
    @(negedge clk);
    checkOutput("single.lat2", 36'(rsp_valid), 36'd0);
    @(negedge clk);
    checkOutput("single.lat3", 36'(rsp_valid), 36'd1);
    @(posedge clk);
    #1;
    waitIdle(20, "single.idle");

    // Operand 1.0 gives 2 and operand 3.0 gives 8; also an idle cycle.
    req_data = packOps(12'h000, 12'h040, 12'h000, 12'h000);
    applyStimulus(4'b0010, 4'b0010, 34'd2, 1'b1, "op040");
    req_data = packOps(12'h000, 12'h000, 12'h000, 12'h0C0);
    applyStimulus(4'b1000, 4'b1000, 34'd8, 1'b1, "op0C0");
    applyStimulus(4'b0000, 4'b0000, 34'd0, 1'b0, "idle");
    waitIdle(20, "ops.idle");

    // Backpressure: only 4 issues fit, then the grants stop.
    rsp_ready = 1'b0;
    req_data  = packOps(12'h100, 12'h140, 12'h180, 12'h1C0);
`ifdef MATH_POW2_ARB_PRIO_EN
    for (int i = 0; i < 4; i++) applyStimulus(4'hF, 4'b0001, 34'd16, 1'b1, "bp");
`else
    applyStimulus(4'hF, 4'b0001, 34'd16, 1'b1, "bp0");
    applyStimulus(4'hF, 4'b0010, 34'd32, 1'b1, "bp1");
    applyStimulus(4'hF, 4'b0100, 34'd64, 1'b1, "bp2");
    applyStimulus(4'hF, 4'b1000, 34'd128, 1'b1, "bp3");
`endif
    for (int i = 0; i < 4; i++) applyStimulus(4'hF, 4'b0000, 34'd0, 1'b0, "bpFull");
    req_valid = 4'h0;
    @(negedge clk);
    checkOutput("bp.busy", 36'(busy), 36'd1);
    checkOutput("bp.queued", 36'(sbQ.size()), 36'd4);
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    waitIdle(20, "bp.idle");
    checkOutput("bp.drained", 36'(sbQ.size()), 36'd0);

    // Reset while two operations are in flight: both are discarded.
    req_data = packOps(12'h080, 12'h0C0, 12'h000, 12'h000);
    applyStimulus(4'b0001, 4'b0001, 34'd0, 1'b0, "rst.issueA");
    applyStimulus(4'b0010, 4'b0010, 34'd0, 1'b0, "rst.issueB");
    req_valid = 4'h0;
    checkOutput("rst.busyBefore", 36'(busy), 36'd1);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("rst.busyDuring", 36'(busy), 36'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput("rst.rspValid", 36'(rsp_valid), 36'd0);
      checkOutput("rst.busy", 36'(busy), 36'd0);
    end
    @(posedge clk);
    #1;

    // Requesters 0 and 3 continuously valid until credit runs out.
    rsp_ready = 1'b0;
    req_data  = packOps(12'h040, 12'h000, 12'h000, 12'h0C0);
`ifdef MATH_POW2_ARB_PRIO_EN
    for (int i = 0; i < 4; i++) applyStimulus(4'b1001, 4'b0001, 34'd2, 1'b1, "prio");
`else
    applyStimulus(4'b1001, 4'b0001, 34'd2, 1'b1, "pair0");
    applyStimulus(4'b1001, 4'b1000, 34'd8, 1'b1, "pair1");
    applyStimulus(4'b1001, 4'b0001, 34'd2, 1'b1, "pair2");
    applyStimulus(4'b1001, 4'b1000, 34'd8, 1'b1, "pair3");
`endif
    applyStimulus(4'b1001, 4'b0000, 34'd0, 1'b0, "pairFull0");
    applyStimulus(4'b1001, 4'b0000, 34'd0, 1'b0, "pairFull1");
    req_valid = 4'h0;
    rsp_ready = 1'b1;
    waitIdle(20, "pair.idle");
    checkOutput("final.drained", 36'(sbQ.size()), 36'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
